// File: rtl/pc_branch_unit_if.sv
// Control-flow request / fetch-address bundle between the decoder side (master)
// and the program-counter stage (slave).
interface pc_branch_unit_if #(
   parameter int unsigned PC_W        = 10,
   parameter int unsigned STACK_DEPTH = 16
);

   localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH) + 1;

   // Request side: decoded op, destination and the selected flag bit.
   logic                en;
   logic [2:0]          op;
   logic [PC_W-1:0]     target;
   logic                cond;

   // Response side: registered fetch state.
   logic [PC_W-1:0]     pc;
   logic                halted;
   logic [DEPTH_W-1:0]  depth;
   logic                stack_ovf;
   logic                stack_unf;

   modport master (
      output en, op, target, cond,
      input  pc, halted, depth, stack_ovf, stack_unf
   );

   modport slave (
      input  en, op, target, cond,
      output pc, halted, depth, stack_ovf, stack_unf
   );

endinterface

// File: rtl/pc_branch_unit.sv
// Program counter and control-flow stage: sequential fetch, jump, conditional
// branch, call/return through a hardware return-address stack, and halt.
// All outputs come straight from registers.
module pc_branch_unit #(
   parameter int unsigned PC_W        = 10,
   parameter int unsigned STACK_DEPTH = 16
) (
   input logic             clk,
   input logic             rst,
   pc_branch_unit_if.slave bus
);

   localparam int unsigned AW = $clog2(STACK_DEPTH);
   localparam int unsigned DW = AW + 1;

   typedef enum logic [2:0] {
      OpInc = 3'b000,
      OpJmp = 3'b001,
      OpBrh = 3'b010,
      OpCal = 3'b011,
      OpRet = 3'b100,
      OpHlt = 3'b101
   } op_e;

   typedef enum logic {
      StRun  = 1'b0,
      StHalt = 1'b1
   } state_e;

   state_e          state_q;
   logic [PC_W-1:0] pc_q;
   logic [DW-1:0]   depth_q;
   logic            ovf_q;
   logic            unf_q;
   logic [PC_W-1:0] stack_q [STACK_DEPTH];

   op_e             op;
   logic            advance;
   logic            full;
   logic            empty;
   logic            push;
   logic [PC_W-1:0] pc_inc;
   logic [PC_W-1:0] top;
   logic [DW-1:0]   depth_dec;
   logic [AW-1:0]   wr_idx;
   logic [AW-1:0]   rd_idx;

   // Decode and stack addressing; the top entry is read combinationally.
   always_comb begin
      op        = op_e'(bus.op);
      advance   = bus.en && (state_q == StRun);
      full      = (depth_q == DW'(STACK_DEPTH));
      empty     = (depth_q == '0);
      pc_inc    = pc_q + PC_W'(1);
      depth_dec = depth_q - DW'(1);
      // When full the write index aliases entry 0, but push is blocked then.
      wr_idx    = depth_q[AW-1:0];
      rd_idx    = depth_dec[AW-1:0];
      top       = stack_q[rd_idx];
      push      = !rst && advance && (op == OpCal) && !full;
   end

   // Control state: pc, stack depth, run/halt and sticky error flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StRun;
         pc_q    <= '0;
         depth_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else if (advance) begin
         case (op)
            OpJmp: pc_q <= bus.target;
            OpBrh: pc_q <= bus.cond ? bus.target : pc_inc;
            OpCal: begin
               pc_q <= bus.target;
               if (full) begin
                  ovf_q <= 1'b1;
               end else begin
                  depth_q <= depth_q + DW'(1);
               end
            end
            OpRet: begin
               if (empty) begin
                  pc_q  <= pc_inc;
                  unf_q <= 1'b1;
               end else begin
                  pc_q    <= top;
                  depth_q <= depth_dec;
               end
            end
            OpHlt:   state_q <= StHalt;
            // 110/111 fall through to sequential fetch.
            default: pc_q <= pc_inc;
         endcase
      end
   end

   // Return-address storage; contents need no reset since depth gates reads.
   always_ff @(posedge clk) begin
      if (push) begin
         stack_q[wr_idx] <= pc_inc;
      end
   end

   // Registered outputs.
   always_comb begin
      bus.pc        = pc_q;
      bus.halted    = (state_q == StHalt);
      bus.depth     = depth_q;
      bus.stack_ovf = ovf_q;
      bus.stack_unf = unf_q;
   end

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed table-driven bench for pc_branch_unit plus hand-written stack
// fill/unwind and mid-sequence reset sequences.
module tb_pc_branch_unit;

   localparam int unsigned PC_W = 10;
   localparam int unsigned SD   = 16;
   localparam int unsigned DW   = 5;

   localparam logic [2:0] INC = 3'b000;
   localparam logic [2:0] JMP = 3'b001;
   localparam logic [2:0] BRH = 3'b010;
   localparam logic [2:0] CAL = 3'b011;
   localparam logic [2:0] RET = 3'b100;
   localparam logic [2:0] HLT = 3'b101;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   pc_branch_unit_if #(.PC_W(PC_W), .STACK_DEPTH(SD)) bus ();

   pc_branch_unit #(.PC_W(PC_W), .STACK_DEPTH(SD)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      string           name;
      logic            r;
      logic            en;
      logic [2:0]      op;
      logic [PC_W-1:0] tgt;
      logic            c;
      logic [PC_W-1:0] pc;
      logic            h;
      logic [DW-1:0]   d;
      logic            ovf;
      logic            unf;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input string n, input logic r, input logic en,
                               input logic [2:0] op, input logic [PC_W-1:0] tgt,
                               input logic c, input logic [PC_W-1:0] pc, input logic h,
                               input logic [DW-1:0] d, input logic ovf, input logic unf);
      vec_t v;
      v.name = n; v.r = r; v.en = en; v.op = op; v.tgt = tgt; v.c = c;
      v.pc = pc; v.h = h; v.d = d; v.ovf = ovf; v.unf = unf;
      vecs.push_back(v);
   endfunction

   // Apply one cycle of inputs and sample #1 after the edge.
   task automatic step(input logic r, input logic en, input logic [2:0] op,
                       input logic [PC_W-1:0] tgt, input logic c);
      rst        = r;
      bus.en     = en;
      bus.op     = op;
      bus.target = tgt;
      bus.cond   = c;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_state(input string n, input logic [PC_W-1:0] pc, input logic h,
                               input logic [DW-1:0] d, input logic ovf, input logic unf);
      checks++;
      if ({bus.pc, bus.halted, bus.depth, bus.stack_ovf, bus.stack_unf} !==
          {pc, h, d, ovf, unf}) begin
         errors++;
         $display("FAIL %s: got pc=%h halted=%b depth=%0d ovf=%b unf=%b, want pc=%h halted=%b depth=%0d ovf=%b unf=%b",
                  n, bus.pc, bus.halted, bus.depth, bus.stack_ovf, bus.stack_unf,
                  pc, h, d, ovf, unf);
      end
   endtask

   logic [PC_W-1:0] model_stk [SD];
   int              md;
   logic [PC_W-1:0] mpc;
   logic [PC_W-1:0] tgt;

   initial begin
      rst        = 1'b1;
      bus.en     = 1'b0;
      bus.op     = INC;
      bus.target = '0;
      bus.cond   = 1'b0;

      //   name         rst en op   target  c   pc      h  d  ovf unf
      add("reset",      1, 1, INC, 10'h000, 0, 10'h000, 0, 0, 0, 0);
      add("inc1",       0, 1, INC, 10'h000, 0, 10'h001, 0, 0, 0, 0);
      add("inc2",       0, 1, INC, 10'h000, 0, 10'h002, 0, 0, 0, 0);
      add("inc3",       0, 1, INC, 10'h000, 0, 10'h003, 0, 0, 0, 0);
      add("jmp_max",    0, 1, JMP, 10'h3FF, 0, 10'h3FF, 0, 0, 0, 0);
      add("inc_wrap",   0, 1, INC, 10'h000, 0, 10'h000, 0, 0, 0, 0);
      add("brh_taken",  0, 1, BRH, 10'h155, 1, 10'h155, 0, 0, 0, 0);
      add("brh_not",    0, 1, BRH, 10'h155, 0, 10'h156, 0, 0, 0, 0);
      add("stall1",     0, 0, JMP, 10'h2AA, 1, 10'h156, 0, 0, 0, 0);
      add("stall2",     0, 0, JMP, 10'h2AA, 1, 10'h156, 0, 0, 0, 0);
      add("stall3",     0, 0, JMP, 10'h2AA, 1, 10'h156, 0, 0, 0, 0);
      add("stall4",     0, 0, JMP, 10'h2AA, 1, 10'h156, 0, 0, 0, 0);
      add("jmp_010",    0, 1, JMP, 10'h010, 0, 10'h010, 0, 0, 0, 0);
      add("cal_200",    0, 1, CAL, 10'h200, 0, 10'h200, 0, 1, 0, 0);
      add("cal_300",    0, 1, CAL, 10'h300, 0, 10'h300, 0, 2, 0, 0);
      add("ret_201",    0, 1, RET, 10'h000, 0, 10'h201, 0, 1, 0, 0);
      add("ret_011",    0, 1, RET, 10'h000, 0, 10'h011, 0, 0, 0, 0);
      add("jmp_040",    0, 1, JMP, 10'h040, 0, 10'h040, 0, 0, 0, 0);
      add("ret_unf",    0, 1, RET, 10'h000, 0, 10'h041, 0, 0, 0, 1);
      add("op6_inc",    0, 1, 3'b110, 10'h3A0, 1, 10'h042, 0, 0, 0, 1);
      add("op7_inc",    0, 1, 3'b111, 10'h3A0, 1, 10'h043, 0, 0, 0, 1);
      add("stall_cal",  0, 0, CAL, 10'h1F0, 0, 10'h043, 0, 0, 0, 1);
      add("jmp_022",    0, 1, JMP, 10'h022, 0, 10'h022, 0, 0, 0, 1);
      add("hlt",        0, 1, HLT, 10'h0FF, 0, 10'h022, 1, 0, 0, 1);
      add("halt_jmp1",  0, 1, JMP, 10'h100, 1, 10'h022, 1, 0, 0, 1);
      add("halt_cal1",  0, 1, CAL, 10'h200, 0, 10'h022, 1, 0, 0, 1);
      add("halt_jmp2",  0, 1, JMP, 10'h300, 0, 10'h022, 1, 0, 0, 1);
      add("halt_cal2",  0, 1, CAL, 10'h3FF, 0, 10'h022, 1, 0, 0, 1);
      add("halt_ret",   0, 1, RET, 10'h000, 0, 10'h022, 1, 0, 0, 1);
      add("rst_halted", 1, 0, JMP, 10'h155, 1, 10'h000, 0, 0, 0, 0);
      add("post_rst",   0, 1, INC, 10'h000, 0, 10'h001, 0, 0, 0, 0);

      foreach (vecs[i]) begin
         step(vecs[i].r, vecs[i].en, vecs[i].op, vecs[i].tgt, vecs[i].c);
         expect_state(vecs[i].name, vecs[i].pc, vecs[i].h, vecs[i].d, vecs[i].ovf,
                      vecs[i].unf);
      end

      // Fill the stack back-to-back, overflow, then unwind with a stall midway.
      step(1, 1, INC, 10'h000, 0);
      expect_state("ovf_reset", 10'h000, 0, 0, 0, 0);
      step(0, 1, JMP, 10'h080, 0);
      mpc = 10'h080;
      md  = 0;
      expect_state("ovf_start", mpc, 0, 0, 0, 0);
      for (int i = 0; i < 16; i++) begin
         tgt = 10'h100 + 10'(i * 16);
         step(0, 1, CAL, tgt, 0);
         model_stk[md] = mpc + 10'd1;
         md++;
         mpc = tgt;
         expect_state("ovf_fill", mpc, 0, DW'(md), 0, 0);
      end
      step(0, 1, CAL, 10'h3FF, 0);
      mpc = 10'h3FF;
      expect_state("ovf_17th", mpc, 0, 5'd16, 1, 0);
      for (int i = 0; i < 16; i++) begin
         if (i == 8) begin
            for (int s = 0; s < 3; s++) begin
               step(0, 0, RET, 10'h000, 0);
               expect_state("unwind_stall", mpc, 0, DW'(md), 1, 0);
            end
         end
         step(0, 1, RET, 10'h000, 0);
         md--;
         mpc = model_stk[md];
         expect_state("unwind", mpc, 0, DW'(md), 1, 0);
      end
      step(0, 1, RET, 10'h000, 0);
      expect_state("unwind_unf", mpc + 10'd1, 0, 0, 1, 1);

      // Reset with depth=5 and a CAL presented: stack must read as empty after.
      step(1, 1, INC, 10'h000, 0);
      for (int i = 0; i < 5; i++) begin
         step(0, 1, CAL, 10'h050 + 10'(i), 0);
      end
      expect_state("depth5", 10'h054, 0, 5, 0, 0);
      step(1, 1, CAL, 10'h3C0, 0);
      expect_state("rst_depth5", 10'h000, 0, 0, 0, 0);
      step(0, 1, RET, 10'h000, 0);
      expect_state("rst_then_ret", 10'h001, 0, 0, 0, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
